// File: rtl/alu_reservation_station_pkg.sv
// Shared widths for the ALU reservation station: ROB tag size, entry count and work_type layout.
package alu_reservation_station_pkg;

    localparam int unsigned RS_SIZE_BITS = 3;
    localparam int unsigned ROB_SIZE_W   = 4;
    localparam int unsigned WORK_TYPE_W  = 5;
    localparam int unsigned XLEN         = 32;

    localparam logic [WORK_TYPE_W-1:0] WT_ADD = 5'd0;
    localparam logic [WORK_TYPE_W-1:0] WT_SUB = 5'd1;
    localparam logic [WORK_TYPE_W-1:0] WT_BEQ = 5'd16;

endpackage

// File: rtl/alu_reservation_station_rs_select.sv
// Dual lowest-index priority encoder: first free slot and first ready slot.
module rs_select #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N-1:0]     i_busy,
    input  logic [N-1:0]     i_ready,
    output logic [IDX_W-1:0] o_free_idx,
    output logic             o_has_free,
    output logic [IDX_W-1:0] o_ready_idx,
    output logic             o_has_ready
);

    always_comb begin
        o_free_idx  = '0;
        o_ready_idx = '0;
        // Scan downwards so the lowest matching index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (!i_busy[i]) begin
                o_free_idx = IDX_W'(i);
            end
            if (i_ready[i]) begin
                o_ready_idx = IDX_W'(i);
            end
        end
        o_has_free  = ~&i_busy;
        o_has_ready = |i_ready;
    end

endmodule

// File: rtl/alu_reservation_station.sv
// Eight-entry issue buffer in front of the integer ALU; captures operands from the ALU and LSB
// result buses and sends at most one ready instruction per cycle.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int unsigned RS_BITS = RS_SIZE_BITS,
    parameter int unsigned ROB_W   = ROB_SIZE_W
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_rdy,
    input  logic                   i_clear,

    input  logic                   i_issue_valid,
    input  logic [WORK_TYPE_W-1:0] i_issue_type,
    input  logic [ROB_W-1:0]       i_issue_rob_id,
    input  logic [XLEN-1:0]        i_issue_vj,
    input  logic [XLEN-1:0]        i_issue_vk,
    input  logic                   i_issue_has_qj,
    input  logic                   i_issue_has_qk,
    input  logic [ROB_W-1:0]       i_issue_qj,
    input  logic [ROB_W-1:0]       i_issue_qk,
    output logic                   o_full,

    input  logic                   i_alu_cdb_ready,
    input  logic [ROB_W-1:0]       i_alu_cdb_rob_id,
    input  logic [XLEN-1:0]        i_alu_cdb_value,
    input  logic                   i_lsb_cdb_ready,
    input  logic [ROB_W-1:0]       i_lsb_cdb_rob_id,
    input  logic [XLEN-1:0]        i_lsb_cdb_value,

    output logic                   o_alu_valid,
    output logic [WORK_TYPE_W-1:0] o_alu_type,
    output logic [XLEN-1:0]        o_alu_r1,
    output logic [XLEN-1:0]        o_alu_r2,
    output logic [ROB_W-1:0]       o_alu_rob_id
);

    localparam int unsigned RS_N = 1 << RS_BITS;

    logic [RS_N-1:0]        r_busy;
    logic [RS_N-1:0]        r_has_qj;
    logic [RS_N-1:0]        r_has_qk;
    logic [WORK_TYPE_W-1:0] r_type   [RS_N];
    logic [XLEN-1:0]        r_vj     [RS_N];
    logic [XLEN-1:0]        r_vk     [RS_N];
    logic [ROB_W-1:0]       r_qj     [RS_N];
    logic [ROB_W-1:0]       r_qk     [RS_N];
    logic [ROB_W-1:0]       r_rob_id [RS_N];

    logic                   r_alu_valid;
    logic [WORK_TYPE_W-1:0] r_alu_type;
    logic [XLEN-1:0]        r_alu_r1;
    logic [XLEN-1:0]        r_alu_r2;
    logic [ROB_W-1:0]       r_alu_rob_id;

    logic [RS_N-1:0]        w_ready;
    logic [RS_BITS-1:0]     w_free_idx;
    logic                   w_has_free;
    logic [RS_BITS-1:0]     w_ready_idx;
    logic                   w_has_ready;

    logic [RS_N-1:0]        w_wake_j;
    logic [RS_N-1:0]        w_wake_k;
    logic [XLEN-1:0]        w_wake_vj [RS_N];
    logic [XLEN-1:0]        w_wake_vk [RS_N];

    logic                   w_iss_has_qj;
    logic                   w_iss_has_qk;
    logic [XLEN-1:0]        w_iss_vj;
    logic [XLEN-1:0]        w_iss_vk;

    assign w_ready = r_busy & ~r_has_qj & ~r_has_qk;
    assign o_full  = &r_busy;

    rs_select #(
        .N     (RS_N),
        .IDX_W (RS_BITS)
    ) u_rs_select (
        .i_busy      (r_busy),
        .i_ready     (w_ready),
        .o_free_idx  (w_free_idx),
        .o_has_free  (w_has_free),
        .o_ready_idx (w_ready_idx),
        .o_has_ready (w_has_ready)
    );

    // Tag match against both result buses; the ALU bus takes precedence.
    always_comb begin
        for (int i = 0; i < RS_N; i++) begin
            w_wake_j[i]  = 1'b0;
            w_wake_k[i]  = 1'b0;
            w_wake_vj[i] = '0;
            w_wake_vk[i] = '0;
            if (r_busy[i] && r_has_qj[i]) begin
                if (i_alu_cdb_ready && i_alu_cdb_rob_id == r_qj[i]) begin
                    w_wake_j[i]  = 1'b1;
                    w_wake_vj[i] = i_alu_cdb_value;
                end else if (i_lsb_cdb_ready && i_lsb_cdb_rob_id == r_qj[i]) begin
                    w_wake_j[i]  = 1'b1;
                    w_wake_vj[i] = i_lsb_cdb_value;
                end
            end
            if (r_busy[i] && r_has_qk[i]) begin
                if (i_alu_cdb_ready && i_alu_cdb_rob_id == r_qk[i]) begin
                    w_wake_k[i]  = 1'b1;
                    w_wake_vk[i] = i_alu_cdb_value;
                end else if (i_lsb_cdb_ready && i_lsb_cdb_rob_id == r_qk[i]) begin
                    w_wake_k[i]  = 1'b1;
                    w_wake_vk[i] = i_lsb_cdb_value;
                end
            end
        end
    end

    always_comb begin
        w_iss_has_qj = i_issue_has_qj;
        w_iss_has_qk = i_issue_has_qk;
        w_iss_vj     = i_issue_vj;
        w_iss_vk     = i_issue_vk;
        if (i_issue_has_qj) begin
            if (i_alu_cdb_ready && i_alu_cdb_rob_id == i_issue_qj) begin
                w_iss_has_qj = 1'b0;
                w_iss_vj     = i_alu_cdb_value;
            end else if (i_lsb_cdb_ready && i_lsb_cdb_rob_id == i_issue_qj) begin
                w_iss_has_qj = 1'b0;
                w_iss_vj     = i_lsb_cdb_value;
            end
        end
        if (i_issue_has_qk) begin
            if (i_alu_cdb_ready && i_alu_cdb_rob_id == i_issue_qk) begin
                w_iss_has_qk = 1'b0;
                w_iss_vk     = i_alu_cdb_value;
            end else if (i_lsb_cdb_ready && i_lsb_cdb_rob_id == i_issue_qk) begin
                w_iss_has_qk = 1'b0;
                w_iss_vk     = i_lsb_cdb_value;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy       <= '0;
            r_has_qj     <= '0;
            r_has_qk     <= '0;
            for (int i = 0; i < RS_N; i++) begin
                r_type[i]   <= '0;
                r_vj[i]     <= '0;
                r_vk[i]     <= '0;
                r_qj[i]     <= '0;
                r_qk[i]     <= '0;
                r_rob_id[i] <= '0;
            end
            r_alu_valid  <= 1'b0;
            r_alu_type   <= '0;
            r_alu_r1     <= '0;
            r_alu_r2     <= '0;
            r_alu_rob_id <= '0;
        end else if (i_rdy) begin
            if (i_clear) begin
                r_busy      <= '0;
                r_alu_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_N; i++) begin
                    if (w_wake_j[i]) begin
                        r_has_qj[i] <= 1'b0;
                        r_vj[i]     <= w_wake_vj[i];
                    end
                    if (w_wake_k[i]) begin
                        r_has_qk[i] <= 1'b0;
                        r_vk[i]     <= w_wake_vk[i];
                    end
                end

                r_alu_valid <= w_has_ready;
                if (w_has_ready) begin
                    r_alu_type           <= r_type[w_ready_idx];
                    r_alu_r1             <= r_vj[w_ready_idx];
                    r_alu_r2             <= r_vk[w_ready_idx];
                    r_alu_rob_id         <= r_rob_id[w_ready_idx];
                    r_busy[w_ready_idx]  <= 1'b0;
                end

                // A free slot is never the selected one, so these writes cannot collide.
                if (i_issue_valid && w_has_free) begin
                    r_busy[w_free_idx]   <= 1'b1;
                    r_type[w_free_idx]   <= i_issue_type;
                    r_rob_id[w_free_idx] <= i_issue_rob_id;
                    r_qj[w_free_idx]     <= i_issue_qj;
                    r_qk[w_free_idx]     <= i_issue_qk;
                    r_has_qj[w_free_idx] <= w_iss_has_qj;
                    r_has_qk[w_free_idx] <= w_iss_has_qk;
                    r_vj[w_free_idx]     <= w_iss_vj;
                    r_vk[w_free_idx]     <= w_iss_vk;
                end
            end
        end
    end

    assign o_alu_valid  = r_alu_valid;
    assign o_alu_type   = r_alu_type;
    assign o_alu_r1     = r_alu_r1;
    assign o_alu_r2     = r_alu_r2;
    assign o_alu_rob_id = r_alu_rob_id;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: vector table plus multi-cycle sequences, checked by scoreboard.
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    localparam int unsigned RW = ROB_SIZE_W;
    localparam int NV = 8;

    logic          clk = 1'b0;
    logic          rst, rdy, clear;
    logic          issue_valid;
    logic [4:0]    issue_type;
    logic [RW-1:0] issue_rob_id, issue_qj, issue_qk;
    logic [31:0]   issue_vj, issue_vk;
    logic          issue_has_qj, issue_has_qk;
    logic          full;
    logic          alu_cdb_ready, lsb_cdb_ready;
    logic [RW-1:0] alu_cdb_rob_id, lsb_cdb_rob_id;
    logic [31:0]   alu_cdb_value, lsb_cdb_value;
    logic          alu_valid;
    logic [4:0]    alu_type;
    logic [31:0]   alu_r1, alu_r2;
    logic [RW-1:0] alu_rob_id;

    always #5 clk = ~clk;

    alu_reservation_station dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_rdy            (rdy),
        .i_clear          (clear),
        .i_issue_valid    (issue_valid),
        .i_issue_type     (issue_type),
        .i_issue_rob_id   (issue_rob_id),
        .i_issue_vj       (issue_vj),
        .i_issue_vk       (issue_vk),
        .i_issue_has_qj   (issue_has_qj),
        .i_issue_has_qk   (issue_has_qk),
        .i_issue_qj       (issue_qj),
        .i_issue_qk       (issue_qk),
        .o_full           (full),
        .i_alu_cdb_ready  (alu_cdb_ready),
        .i_alu_cdb_rob_id (alu_cdb_rob_id),
        .i_alu_cdb_value  (alu_cdb_value),
        .i_lsb_cdb_ready  (lsb_cdb_ready),
        .i_lsb_cdb_rob_id (lsb_cdb_rob_id),
        .i_lsb_cdb_value  (lsb_cdb_value),
        .o_alu_valid      (alu_valid),
        .o_alu_type       (alu_type),
        .o_alu_r1         (alu_r1),
        .o_alu_r2         (alu_r2),
        .o_alu_rob_id     (alu_rob_id)
    );

    typedef struct {
        logic [4:0]    t;
        logic [31:0]   r1;
        logic [31:0]   r2;
        logic [RW-1:0] rob;
        int            cyc;
    } exp_t;

    typedef struct {
        logic [4:0]    t;
        logic [RW-1:0] rob;
        logic [31:0]   vj, vk;
        logic          hqj;
        logic [RW-1:0] qj;
        logic          hqk;
        logic [RW-1:0] qk;
        logic          ar;
        logic [RW-1:0] at;
        logic [31:0]   av;
        logic          lr;
        logic [RW-1:0] lt;
        logic [31:0]   lv;
        logic [31:0]   e1, e2;
    } vec_t;

    exp_t sb[$];
    exp_t last;
    exp_t mon_e;
    vec_t vecs[NV];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic mon_rdy, mon_rst;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [4:0] t, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [RW-1:0] rob, input int c);
        exp_t e;
        e.t = t; e.r1 = r1; e.r2 = r2; e.rob = rob; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic idle();
        clear = 1'b0; issue_valid = 1'b0; issue_type = '0; issue_rob_id = '0;
        issue_vj = '0; issue_vk = '0; issue_has_qj = 1'b0; issue_has_qk = 1'b0;
        issue_qj = '0; issue_qk = '0;
        alu_cdb_ready = 1'b0; alu_cdb_rob_id = '0; alu_cdb_value = '0;
        lsb_cdb_ready = 1'b0; lsb_cdb_rob_id = '0; lsb_cdb_value = '0;
    endtask

    task automatic drv_issue(input logic [4:0] t, input logic [RW-1:0] rob,
                             input logic [31:0] vj, input logic [31:0] vk,
                             input logic hqj, input logic [RW-1:0] qj,
                             input logic hqk, input logic [RW-1:0] qk);
        issue_valid = 1'b1; issue_type = t; issue_rob_id = rob;
        issue_vj = vj; issue_vk = vk; issue_has_qj = hqj; issue_qj = qj;
        issue_has_qk = hqk; issue_qk = qk;
    endtask

    // Compare each dispatch (only at edges where the station was enabled) against the scoreboard.
    always @(posedge clk) begin
        cyc++;
        mon_rdy = rdy;
        mon_rst = rst;
        #1;
        if (!mon_rst && mon_rdy && alu_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dispatch: got rob %0d want none (cycle %0d)",
                         alu_rob_id, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("disp_rob", 32'(alu_rob_id), 32'(mon_e.rob));
                chk("disp_type", 32'(alu_type), 32'(mon_e.t));
                chk("disp_r1", alu_r1, mon_e.r1);
                chk("disp_r2", alu_r2, mon_e.r2);
                chk("disp_cycle", 32'(cyc), 32'(mon_e.cyc));
                last = mon_e;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{5'd0, 4'd3, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0,
                    1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd5, 32'd7};
        vecs[1] = '{5'd1, 4'd6, 32'hbad, 32'd2, 1'b1, 4'd6, 1'b0, 4'd0,
                    1'b1, 4'd6, 32'd9, 1'b0, 4'd0, 32'd0, 32'd9, 32'd2};
        vecs[2] = '{5'd2, 4'd7, 32'h11, 32'hbad, 1'b0, 4'd0, 1'b1, 4'd5,
                    1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 32'hdead, 32'h11, 32'hdead};
        vecs[3] = '{5'd4, 4'd8, 32'hbad, 32'hbad, 1'b1, 4'd2, 1'b1, 4'd3,
                    1'b1, 4'd2, 32'ha, 1'b1, 4'd3, 32'hb, 32'ha, 32'hb};
        vecs[4] = '{5'd5, 4'd9, 32'hbad, 32'd3, 1'b1, 4'd4, 1'b0, 4'd0,
                    1'b1, 4'd4, 32'h1234, 1'b1, 4'd4, 32'h9999, 32'h1234, 32'd3};
        vecs[5] = '{5'd6, 4'd10, 32'h77, 32'h88, 1'b0, 4'd1, 1'b0, 4'd1,
                    1'b1, 4'd1, 32'h55, 1'b1, 4'd1, 32'h66, 32'h77, 32'h88};
        vecs[6] = '{5'd8, 4'd11, 32'hbad, 32'hbad, 1'b1, 4'd7, 1'b1, 4'd7,
                    1'b1, 4'd7, 32'h42, 1'b0, 4'd0, 32'd0, 32'h42, 32'h42};
        vecs[7] = '{5'h1f, 4'd15, 32'hffffffff, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0,
                    1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'hffffffff, 32'd0};

        rst = 1'b1;
        rdy = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(alu_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_type", 32'(alu_type), 32'd0);
        chk("rst_r1", alu_r1, 32'd0);
        chk("rst_r2", alu_r2, 32'd0);
        chk("rst_rob", 32'(alu_rob_id), 32'd0);
        rst = 1'b0;

        // Back-to-back vectors, each ready at issue (possibly via same-cycle forwarding).
        for (int i = 0; i < NV; i++) begin
            drv_issue(vecs[i].t, vecs[i].rob, vecs[i].vj, vecs[i].vk,
                      vecs[i].hqj, vecs[i].qj, vecs[i].hqk, vecs[i].qk);
            alu_cdb_ready = vecs[i].ar; alu_cdb_rob_id = vecs[i].at; alu_cdb_value = vecs[i].av;
            lsb_cdb_ready = vecs[i].lr; lsb_cdb_rob_id = vecs[i].lt; lsb_cdb_value = vecs[i].lv;
            push(vecs[i].t, vecs[i].e1, vecs[i].e2, vecs[i].rob, cyc + 2);
            @(negedge clk);
        end
        idle();
        repeat (2) @(negedge clk);
        chk("table_drained", 32'(sb.size()), 32'd0);
        chk("table_full", 32'(full), 32'd0);

        // Pending qj woken two cycles after issue by the LSB bus.
        drv_issue(WT_ADD, 4'd4, 32'hdeadbeef, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0);
        @(negedge clk);
        idle();
        @(negedge clk);
        lsb_cdb_ready = 1'b1; lsb_cdb_rob_id = 4'd2; lsb_cdb_value = 32'h100;
        push(WT_ADD, 32'h100, 32'd1, 4'd4, cyc + 2);
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        chk("wake_drained", 32'(sb.size()), 32'd0);

        // Fill all entries on tag 1, drop a ninth, then release in index order.
        for (int i = 0; i < 8; i++) begin
            drv_issue(5'd3, RW'(8 + i), 32'd0, 32'(i), 1'b1, 4'd1, 1'b0, 4'd0);
            @(negedge clk);
        end
        idle();
        chk("fill_full", 32'(full), 32'd1);
        drv_issue(WT_SUB, 4'd7, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0);
        @(negedge clk);
        idle();
        chk("ninth_full", 32'(full), 32'd1);
        alu_cdb_ready = 1'b1; alu_cdb_rob_id = 4'd1; alu_cdb_value = 32'h55;
        for (int i = 0; i < 8; i++) begin
            push(5'd3, 32'h55, 32'(i), RW'(8 + i), cyc + 2 + i);
        end
        @(negedge clk);
        idle();
        chk("wake_full", 32'(full), 32'd1);
        @(negedge clk);
        chk("first_drain_full", 32'(full), 32'd0);
        repeat (10) @(negedge clk);
        chk("fill_drained", 32'(sb.size()), 32'd0);

        // Flush with pending and ready entries plus a same-cycle issue.
        drv_issue(WT_ADD, 4'd1, 32'd0, 32'd0, 1'b1, 4'd3, 1'b0, 4'd0);
        @(negedge clk);
        drv_issue(WT_ADD, 4'd2, 32'd0, 32'd0, 1'b1, 4'd3, 1'b0, 4'd0);
        @(negedge clk);
        drv_issue(WT_ADD, 4'd5, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0);
        @(negedge clk);
        drv_issue(WT_ADD, 4'd6, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0);
        clear = 1'b1;
        @(negedge clk);
        idle();
        chk("clear_valid", 32'(alu_valid), 32'd0);
        chk("clear_full", 32'(full), 32'd0);
        alu_cdb_ready = 1'b1; alu_cdb_rob_id = 4'd3; alu_cdb_value = 32'h99;
        @(negedge clk);
        idle();
        repeat (4) @(negedge clk);
        chk("clear_drained", 32'(sb.size()), 32'd0);

        // Freeze with a ready entry; issues seen while frozen must be ignored.
        drv_issue(5'd7, 4'd2, 32'h1111, 32'h2222, 1'b0, 4'd0, 1'b0, 4'd0);
        @(negedge clk);
        idle();
        rdy = 1'b0;
        drv_issue(WT_BEQ, 4'd9, 32'd8, 32'd8, 1'b0, 4'd0, 1'b0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("frz_valid", 32'(alu_valid), 32'd0);
            chk("frz_rob", 32'(alu_rob_id), 32'(last.rob));
            chk("frz_r1", alu_r1, last.r1);
            chk("frz_r2", alu_r2, last.r2);
        end
        idle();
        rdy = 1'b1;
        push(5'd7, 32'h1111, 32'h2222, 4'd2, cyc + 1);
        @(negedge clk);
        chk("thaw_valid", 32'(alu_valid), 32'd1);
        @(negedge clk);
        chk("thaw_pulse", 32'(alu_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("thaw_drained", 32'(sb.size()), 32'd0);
        chk("end_full", 32'(full), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
